// File: rtl/snake_body_ctrl.sv
// snake_body_ctrl: snake body shift register with timed movement, growth, wall/self collision and render query
module snake_body_ctrl #(
    parameter int MAX_LEN  = 16,
    parameter int TICK_DIV = 250000,
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] dir_in,
    input  logic       dir_valid,
    input  logic       add_cube,
    input  logic [5:0] query_x,
    input  logic [5:0] query_y,
    output logic [5:0] head_x,
    output logic [5:0] head_y,
    output logic [5:0] length,
    output logic       query_hit,
    output logic       moved,
    output logic       game_over
);
    localparam int CW = $clog2(TICK_DIV);
    typedef enum logic [1:0] {WAIT, RUN, DEAD} state_t;
    state_t state, state_nx;
    logic [5:0] seg_x [MAX_LEN];
    logic [5:0] seg_y [MAX_LEN];
    logic [1:0] cur_dir, next_dir;
    logic [CW-1:0] cnt;
    logic grow_pending, step, grow, wall, self_hit, hit, dir_ok, start;
    logic [5:0] cand_x, cand_y;
    assign head_x    = seg_x[0];
    assign head_y    = seg_y[0];
    assign game_over = state == DEAD;
    always_comb begin
        step     = state == RUN && cnt == CW'(TICK_DIV - 1);
        grow     = grow_pending | add_cube;
        start    = dir_valid && dir_in != 2'd2;
        cand_x   = next_dir == 2'd2 ? seg_x[0] - 6'd1 : next_dir == 2'd3 ? seg_x[0] + 6'd1 : seg_x[0];
        cand_y   = next_dir == 2'd0 ? seg_y[0] - 6'd1 : next_dir == 2'd1 ? seg_y[0] + 6'd1 : seg_y[0];
        wall     = cand_x == 6'd0 || cand_x == 6'(GRID_W - 1) || cand_y == 6'd0 || cand_y == 6'(GRID_H - 1);
        // in a step cycle the reversal test is against the direction about to take effect
        dir_ok   = dir_valid && dir_in != ((step ? next_dir : cur_dir) ^ 2'd1);
        self_hit = 1'b0;
        hit      = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (6'(i) < length && !(6'(i) == length - 6'd1 && !grow) && seg_x[i] == cand_x && seg_y[i] == cand_y)
                self_hit = 1'b1;
            if (6'(i) < length && seg_x[i] == query_x && seg_y[i] == query_y)
                hit = 1'b1;
        end
        state_nx = state;
        if (state == WAIT && start)
            state_nx = RUN;
        if (step && (wall || self_hit))
            state_nx = DEAD;
    end
    always_ff @(posedge clk)
        state <= !reset ? WAIT : state_nx;
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= i < 3 ? 6'(20 - i) : 6'd0;
                seg_y[i] <= i < 3 ? 6'd15 : 6'd0;
            end
            length       <= 6'(MAX_LEN < 3 ? MAX_LEN : 3);
            cur_dir      <= 2'd3;
            next_dir     <= 2'd3;
            cnt          <= '0;
            grow_pending <= 1'b0;
            query_hit    <= 1'b0;
            moved        <= 1'b0;
        end else begin
            query_hit <= hit;
            moved     <= 1'b0;
            if (state == WAIT) begin
                if (add_cube)
                    grow_pending <= 1'b1;
                if (start) begin
                    cur_dir  <= dir_in;
                    next_dir <= dir_in;
                    cnt      <= '0;
                end
            end else if (state == RUN) begin
                cnt <= step ? '0 : cnt + CW'(1);
                if (add_cube)
                    grow_pending <= 1'b1;
                if (dir_ok)
                    next_dir <= dir_in;
                if (step) begin
                    grow_pending <= 1'b0;
                    cur_dir      <= next_dir;
                    if (!wall && !self_hit) begin
                        for (int i = 1; i < MAX_LEN; i++) begin
                            seg_x[i] <= seg_x[i-1];
                            seg_y[i] <= seg_y[i-1];
                        end
                        seg_x[0] <= cand_x;
                        seg_y[0] <= cand_y;
                        if (grow && length < 6'(MAX_LEN))
                            length <= length + 6'd1;
                        moved <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_snake_body_ctrl.sv
// tb_snake_body_ctrl: queue-based snake model compared every cycle, plus directed literal checkpoints
module tb_snake_body_ctrl;
    localparam int MAX_LEN = 4;
    localparam int TICK    = 4;
    logic clk = 0, reset = 0, dir_valid = 0, add_cube = 0;
    logic [1:0] dir_in = 0;
    logic [5:0] query_x = 0, query_y = 0;
    logic [5:0] head_x, head_y, length;
    logic query_hit, moved, game_over;
    int checks = 0, errors = 0;
    bit live = 0;

    snake_body_ctrl #(.MAX_LEN(MAX_LEN), .TICK_DIV(TICK), .GRID_W(40), .GRID_H(30)) dut (
        .clk(clk), .reset(reset), .dir_in(dir_in), .dir_valid(dir_valid), .add_cube(add_cube),
        .query_x(query_x), .query_y(query_y), .head_x(head_x), .head_y(head_y), .length(length),
        .query_hit(query_hit), .moved(moved), .game_over(game_over));

    always #5 clk = ~clk;

    // model: body as a queue of cells, head at the front
    int bx[$], by[$];
    int m_state, m_cur, m_next, m_cnt, nx, ny;
    bit m_gp, m_hit, m_moved, m_grow, m_die;

    always @(posedge clk) begin
        if (!reset) begin
            bx = {20, 19, 18}; by = {15, 15, 15};
            m_state = 0; m_cur = 3; m_next = 3; m_cnt = 0;
            m_gp = 0; m_hit = 0; m_moved = 0;
        end else begin
            m_hit = 0;
            foreach (bx[k]) if (bx[k] == query_x && by[k] == query_y) m_hit = 1;
            m_moved = 0;
            if (m_state == 0) begin
                if (add_cube) m_gp = 1;
                if (dir_valid && dir_in != 2) begin
                    m_state = 1; m_cur = dir_in; m_next = dir_in; m_cnt = 0;
                end
            end else if (m_state == 1) begin
                if (m_cnt == TICK - 1) begin
                    m_cur = m_next;
                    nx = bx[0] + (m_cur == 3 ? 1 : m_cur == 2 ? -1 : 0);
                    ny = by[0] + (m_cur == 1 ? 1 : m_cur == 0 ? -1 : 0);
                    m_grow = m_gp || add_cube;
                    m_die = nx == 0 || nx == 39 || ny == 0 || ny == 29;
                    for (int k = 0; k < bx.size(); k++)
                        if (bx[k] == nx && by[k] == ny && (m_grow || k != bx.size() - 1)) m_die = 1;
                    if (m_die) m_state = 2;
                    else begin
                        bx.push_front(nx); by.push_front(ny);
                        if (!(m_grow && bx.size() <= MAX_LEN)) begin
                            void'(bx.pop_back()); void'(by.pop_back());
                        end
                        m_moved = 1;
                    end
                    m_gp = 0; m_cnt = 0;
                end else begin
                    m_cnt++;
                    if (add_cube) m_gp = 1;
                end
                if (m_state == 1 && dir_valid && dir_in != (m_cur ^ 1)) m_next = dir_in;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (live) begin
        chk("head_x", head_x, bx[0]);
        chk("head_y", head_y, by[0]);
        chk("length", length, bx.size());
        chk("moved", moved, m_moved);
        chk("game_over", game_over, m_state == 2);
        chk("query_hit", query_hit, m_hit);
    end

    task automatic pulse_dir(input int d);
        dir_in = 2'(d); dir_valid = 1;
        @(negedge clk); dir_valid = 0;
    endtask

    task automatic pulse_add();
        add_cube = 1;
        @(negedge clk); add_cube = 0;
    endtask

    task automatic wait_moved(input string name);
        bit seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk); seen = moved;
        end
        chk({name, "_step_timeout"}, seen, 1);
    endtask

    task automatic lit_head(input string name, input int x, input int y);
        chk({name, "_x"}, head_x, x);
        chk({name, "_y"}, head_y, y);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        reset = 1; live = 1;
        lit_head("rst_head", 20, 15);
        chk("rst_len", length, 3);
        chk("rst_over", game_over, 0);
        pulse_dir(2);
        repeat (6) @(negedge clk);
        lit_head("wait_left_ignored", 20, 15);
        query_x = 19; query_y = 15;
        pulse_dir(3);
        wait_moved("first");
        lit_head("first_head", 21, 15);
        chk("first_len", length, 3);
        chk("first_hit", query_hit, 1);
        query_x = 18;
        @(negedge clk);
        chk("old_tail_miss", query_hit, 0);
        pulse_dir(2);
        wait_moved("reverse");
        lit_head("reverse_ignored", 22, 15);
        pulse_dir(0);
        wait_moved("up");
        lit_head("up_head", 22, 14);
        pulse_add();
        wait_moved("grow");
        lit_head("grow_head", 22, 13);
        chk("grow_len", length, 4);
        query_x = 21; query_y = 15;
        @(negedge clk);
        chk("grow_tail_kept", query_hit, 1);
        pulse_add();
        wait_moved("sat");
        lit_head("sat_head", 22, 12);
        chk("sat_len", length, 4);
        pulse_dir(2);
        wait_moved("loop_l");
        pulse_dir(1);
        wait_moved("loop_d");
        pulse_dir(3);
        wait_moved("loop_r");
        lit_head("tail_chase_legal", 22, 13);
        chk("tail_chase_alive", game_over, 0);
        pulse_dir(0);
        repeat (2) @(negedge clk);
        add_cube = 1;
        @(negedge clk); add_cube = 0;
        chk("self_dead", game_over, 1);
        chk("self_no_move", moved, 0);
        lit_head("self_frozen", 22, 13);
        pulse_dir(1);
        pulse_add();
        repeat (8) @(negedge clk);
        lit_head("dead_frozen", 22, 13);
        chk("dead_len", length, 4);
        query_x = 21; query_y = 13;
        @(negedge clk);
        chk("dead_query", query_hit, 1);
        reset = 0; dir_in = 0; dir_valid = 1;
        @(negedge clk);
        reset = 1; dir_valid = 0;
        lit_head("rst2_head", 20, 15);
        chk("rst2_len", length, 3);
        chk("rst2_over", game_over, 0);
        chk("rst2_hit", query_hit, 0);
        repeat (6) @(negedge clk);
        lit_head("rst2_waiting", 20, 15);
        pulse_dir(3);
        begin
            bit dead = 0;
            for (int i = 0; i < 200 && !dead; i++) begin
                @(negedge clk); dead = game_over;
            end
            chk("wall_timeout", dead, 1);
        end
        lit_head("wall_head", 38, 15);
        chk("wall_moved", moved, 0);
        chk("wall_len", length, 3);
        repeat (3) @(negedge clk);
        live = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/snake_body_ctrl.md
SNAKE_BODY_CTRL -- requirements
Module: snake_body_ctrl

Interface
REQ-001 Parameter MAX_LEN, 16, maximum snake length in segments (2..32).
REQ-002 Parameter TICK_DIV, 250000, clk cycles per snake move step (>=2).
REQ-003 Parameter GRID_W, 40, grid columns; walls at x=0 and x=GRID_W-1.
REQ-004 Parameter GRID_H, 30, grid rows; walls at y=0 and y=GRID_H-1.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 reset  input  1  reset, synchronous, active-low.
REQ-007 dir_in  input  2  requested direction: 0=up (y-1), 1=down (y+1), 2=left (x-1), 3=right (x+1).
REQ-008 dir_valid  input  1  one-cycle qualifier for dir_in.
REQ-009 add_cube  input  1  growth request pulse from the apple/eating logic.
REQ-010 query_x  input  6  renderer column to test against the body.
REQ-011 query_y  input  6  renderer row to test against the body.
REQ-012 head_x  output  6  current head column (registered).
REQ-013 head_y  output  6  current head row (registered).
REQ-014 length  output  6  current segment count (registered).
REQ-015 query_hit  output  1  registered: 1 if (query_x,query_y) of previous cycle matched a valid segment.
REQ-016 moved  output  1  one-cycle pulse on each completed move step.
REQ-017 game_over  output  1  high while in DEAD state.

Function
REQ-018 Body SHALL be stored as arrays seg_x/seg_y[0..MAX_LEN-1]; seg 0 = head; segments with index >= length invalid.
REQ-019 FSM states WAIT, RUN, DEAD; WAIT after reset.
REQ-020 WAIT: dir_valid with dir_in != 2 -> RUN, cur_dir <= dir_in, tick counter = 0; dir_in == 2 ignored.
REQ-021 RUN: tick counter counts 0..TICK_DIV-1; move step occurs in the cycle counter == TICK_DIV-1, counter then returns to 0.
REQ-022 dir_valid in RUN latches next_dir unless dir_in is the reverse of cur_dir (0<->1, 2<->3), which is ignored; latest valid request before a step wins.
REQ-023 At a step cur_dir <= next_dir; candidate head = seg0 offset by one cell in that direction.
REQ-024 add_cube sets grow_pending; step grows if grow_pending or add_cube in the step cycle; grow_pending cleared at every step.
REQ-025 Growth at length == MAX_LEN SHALL be discarded; length saturates.
REQ-026 Wall collision: candidate x in {0, GRID_W-1} or y in {0, GRID_H-1} -> DEAD, body unchanged.
REQ-027 Self collision: candidate equals any valid segment 0..length-1, excluding segment length-1 when not growing -> DEAD, body unchanged.
REQ-028 Legal step: seg[i] <= seg[i-1] for i=1..MAX_LEN-1, seg0 <= candidate; length+1 if growing; moved=1 for that cycle.
REQ-029 DEAD: body, length, head frozen; game_over=1; dir_valid and add_cube ignored; exit only by reset; moved=0 on a fatal step.
REQ-030 query_hit evaluated every cycle in all states, including DEAD, against valid segments; one-cycle latency.
REQ-031 head_x/head_y SHALL always equal seg_x[0]/seg_y[0].

Reset
REQ-032 reset==0 at a clk edge: state WAIT, seg0..2 = (20,15),(19,15),(18,15), others (0,0), length 3, cur_dir=next_dir=3, counter 0, grow_pending 0, query_hit 0, moved 0, game_over 0.
REQ-033 Reset SHALL take priority over any step, growth or direction event in the same cycle, including mid-step and DEAD.

Verification (TICK_DIV=4, MAX_LEN=4)
REQ-034 Reset, dir_valid dir_in=3 -> RUN; 4 cycles later moved=1, head (21,15), length 3, query (19,15) -> query_hit=1, query (18,15) -> 0.
REQ-035 In RUN facing right, dir_valid dir_in=2 -> ignored; next step head x+1; then dir_in=0 -> next step head y-1.
REQ-036 add_cube pulse between steps -> next step length 4, tail unchanged; second add_cube -> next step length stays 4 (saturate).
REQ-037 Drive right from (20,15) until candidate x=39 -> step to x=39 does not occur, game_over=1, head stays (38,15), moved=0.
REQ-038 Length 4, sequence up,left,down -> candidate hits seg 3 tail while not growing -> legal move; same with add_cube in step cycle -> DEAD.
REQ-039 In DEAD, assert reset -> all outputs per REQ-032 next cycle; dir_valid during reset ignored.
